// File: rtl/hub_pkg.sv
// Shared constants, FIFO entry type and id-width helper for the core I/O hub.
package hub_pkg;

    localparam int N_CORES_DEF    = 23;
    localparam int DATA_W_DEF     = 31;
    localparam int REQ_W_DEF      = 4;
    localparam int FIFO_DEPTH_DEF = 16;
    localparam int CNT_W_DEF      = 16;

    // Entry fields are sized for the largest supported configuration (64 cores)
    localparam int MAX_ID_W   = 6;
    localparam int MAX_DATA_W = 64;

    function automatic int id_w(input int n);
        return $clog2(n);
    endfunction

    typedef struct packed {
        logic [MAX_ID_W-1:0]   id;
        logic [MAX_DATA_W-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping at N.
module rr_arbiter
    import hub_pkg::*;
#(
    parameter int N    = 4,
    parameter int ID_W = id_w(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] gnt_idx,
    output logic            any
);

    logic [ID_W:0]   sum;
    logic [ID_W:0]   cand;
    logic            hit;

    // Scan N candidates starting at ptr; the wrap is explicit because N need not be a power of two
    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        any     = 1'b0;
        sum     = '0;
        cand    = '0;
        hit     = 1'b0;
        for (int k = 0; k < N; k++) begin
            sum  = {1'b0, ptr} + (ID_W+1)'(k);
            cand = (sum >= (ID_W+1)'(N)) ? (sum - (ID_W+1)'(N)) : sum;
            hit  = !any && req[cand[ID_W-1:0]];
            grant[cand[ID_W-1:0]] = grant[cand[ID_W-1:0]] | hit;
            gnt_idx = hit ? cand[ID_W-1:0] : gnt_idx;
            any     = any | hit;
        end
    end

endmodule

// File: rtl/core_io_hub.sv
// I/O hub: round-robin delivery of ADC samples to requesting cores, and
// collection of per-core results into a tagged show-ahead output FIFO.
module core_io_hub
    import hub_pkg::*;
#(
    parameter int N_CORES    = N_CORES_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int REQ_W      = REQ_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_W-1:0]         in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [N_CORES*REQ_W-1:0]  core_req,
    output logic [DATA_W-1:0]         core_din,
    output logic [N_CORES-1:0]        core_grant,
    input  logic [N_CORES*DATA_W-1:0] core_dout,
    input  logic [N_CORES*REQ_W-1:0]  core_out_en,
    output logic [DATA_W-1:0]         out_data,
    output logic [id_w(N_CORES)-1:0]  out_core_id,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CNT_W-1:0]          drop_cnt,
    output logic                      overflow
);

    localparam int              ID_W    = id_w(N_CORES);
    localparam int              AW      = $clog2(FIFO_DEPTH);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_CORES - 1);

    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] idx);
        return (idx == LAST_ID) ? '0 : (idx + ID_W'(1));
    endfunction

    logic [N_CORES-1:0] req_any;
    logic [N_CORES-1:0] oen_any;
    logic [DATA_W-1:0]  dout_arr [N_CORES];

    logic [N_CORES-1:0] in_grant;
    logic [ID_W-1:0]    in_idx;
    logic               in_any;
    logic               accept;

    logic [ID_W-1:0]    ptr_in_q, ptr_in_d;
    logic [ID_W-1:0]    ptr_out_q, ptr_out_d;
    logic [N_CORES-1:0] grant_q, grant_d;
    logic [DATA_W-1:0]  din_q, din_d;

    logic [N_CORES-1:0] slot_valid_q, slot_valid_d;
    logic [DATA_W-1:0]  slot_data_q [N_CORES];
    logic [DATA_W-1:0]  slot_data_d [N_CORES];
    logic [N_CORES-1:0] drn_grant;
    logic [ID_W-1:0]    drn_idx;
    logic               drn_any;
    logic [N_CORES-1:0] drain_mask;
    logic [N_CORES-1:0] drop_vec;

    fifo_entry_t        mem_q [FIFO_DEPTH];
    fifo_entry_t        mem_d [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]        count_q, count_d;
    logic               push;
    logic               pop;
    logic               full;

    logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
    logic               overflow_q, overflow_d;
    logic [CNT_W:0]     cnt_sum;

    for (genvar g = 0; g < N_CORES; g++) begin : g_core
        logic              v_d;
        logic [DATA_W-1:0] dat_d;
        logic              drop_d;

        assign req_any[g]  = |core_req[g*REQ_W +: REQ_W];
        assign oen_any[g]  = |core_out_en[g*REQ_W +: REQ_W];
        assign dout_arr[g] = core_dout[g*DATA_W +: DATA_W];

        // A new result is dropped only when the old one stays in the slot this cycle
        always_comb begin
            v_d    = slot_valid_q[g];
            dat_d  = slot_data_q[g];
            drop_d = 1'b0;
            if (oen_any[g]) begin
                if (slot_valid_q[g] && !drain_mask[g]) begin
                    drop_d = 1'b1;
                end else begin
                    v_d   = 1'b1;
                    dat_d = dout_arr[g];
                end
            end else if (drain_mask[g]) begin
                v_d = 1'b0;
            end else begin
                v_d = slot_valid_q[g];
            end
        end

        assign slot_valid_d[g] = v_d;
        assign slot_data_d[g]  = dat_d;
        assign drop_vec[g]     = drop_d;
    end

    rr_arbiter #(.N(N_CORES)) u_arb_in (
        .req     (req_any),
        .ptr     (ptr_in_q),
        .grant   (in_grant),
        .gnt_idx (in_idx),
        .any     (in_any)
    );

    rr_arbiter #(.N(N_CORES)) u_arb_out (
        .req     (slot_valid_q),
        .ptr     (ptr_out_q),
        .grant   (drn_grant),
        .gnt_idx (drn_idx),
        .any     (drn_any)
    );

    assign in_ready   = in_any;
    assign accept     = in_valid & in_any;
    assign full       = (count_q == (AW+1)'(FIFO_DEPTH));
    assign pop        = (count_q != '0) && out_ready;
    assign push       = drn_any && (!full || pop);
    assign drain_mask = push ? drn_grant : '0;

    // Sample delivery to the winning core
    always_comb begin
        grant_d  = accept ? in_grant : '0;
        din_d    = accept ? in_data : din_q;
        ptr_in_d = accept ? next_id(in_idx) : ptr_in_q;
    end

    // Slot drain into the FIFO and FIFO pointer bookkeeping
    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        ptr_out_d = ptr_out_q;
        if (push) begin
            mem_d[wr_ptr_q] = '{id: MAX_ID_W'(drn_idx), data: MAX_DATA_W'(slot_data_q[drn_idx])};
            wr_ptr_d        = wr_ptr_q + AW'(1);
            ptr_out_d       = next_id(drn_idx);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    // Several cores may drop in one cycle; each dropped result is counted
    always_comb begin
        cnt_sum    = {1'b0, drop_cnt_q} + (CNT_W+1)'($countones(drop_vec));
        drop_cnt_d = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
        overflow_d = overflow_q | (|drop_vec);
    end

    // Control and status state
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_in_q     <= '0;
            ptr_out_q    <= '0;
            grant_q      <= '0;
            din_q        <= '0;
            slot_valid_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            drop_cnt_q   <= '0;
            overflow_q   <= 1'b0;
        end else begin
            ptr_in_q     <= ptr_in_d;
            ptr_out_q    <= ptr_out_d;
            grant_q      <= grant_d;
            din_q        <= din_d;
            slot_valid_q <= slot_valid_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            drop_cnt_q   <= drop_cnt_d;
            overflow_q   <= overflow_d;
        end
    end

    // Payload storage is qualified by the slot valids and FIFO count, so it is not reset
    always_ff @(posedge clk) begin
        slot_data_q <= slot_data_d;
        mem_q       <= mem_d;
    end

    assign core_grant  = grant_q;
    assign core_din    = din_q;
    assign out_valid   = (count_q != '0);
    assign out_data    = out_valid ? mem_q[rd_ptr_q].data[DATA_W-1:0] : '0;
    assign out_core_id = out_valid ? mem_q[rd_ptr_q].id[ID_W-1:0] : '0;
    assign drop_cnt    = drop_cnt_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_core_io_hub.sv
// Directed bench for core_io_hub with a queue-based reference model checked every cycle.
module tb_core_io_hub;

    localparam int N     = 23;
    localparam int DW    = 31;
    localparam int RW    = 4;
    localparam int DEPTH = 4;
    localparam int CW    = 16;
    localparam int IDW   = 5;

    logic              clk;
    logic              rst;
    logic [DW-1:0]     in_data;
    logic              in_valid;
    logic              in_ready;
    logic [N*RW-1:0]   core_req;
    logic [DW-1:0]     core_din;
    logic [N-1:0]      core_grant;
    logic [N*DW-1:0]   core_dout;
    logic [N*RW-1:0]   core_out_en;
    logic [DW-1:0]     out_data;
    logic [IDW-1:0]    out_core_id;
    logic              out_valid;
    logic              out_ready;
    logic [CW-1:0]     drop_cnt;
    logic              overflow;

    logic [RW-1:0]     req_f  [N];
    logic [RW-1:0]     oen_f  [N];
    logic [DW-1:0]     dout_f [N];

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign core_req[g*RW +: RW]    = req_f[g];
        assign core_out_en[g*RW +: RW] = oen_f[g];
        assign core_dout[g*DW +: DW]   = dout_f[g];
    end

    core_io_hub #(.N_CORES(N), .DATA_W(DW), .REQ_W(RW), .FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .core_req(core_req), .core_din(core_din), .core_grant(core_grant),
        .core_dout(core_dout), .core_out_en(core_out_en),
        .out_data(out_data), .out_core_id(out_core_id), .out_valid(out_valid),
        .out_ready(out_ready), .drop_cnt(drop_cnt), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int            id;
        logic [DW-1:0] data;
    } ent_t;

    ent_t          m_fifo[$];
    ent_t          m_log[$];
    int            m_ptr_in, m_ptr_out, m_drops;
    bit            m_pend_v [N];
    logic [DW-1:0] m_pend_d [N];
    logic [N-1:0]  exp_grant;
    logic [DW-1:0] exp_din;
    bit            exp_ovf;
    bit            chk_en;
    int            n_tests, n_fail;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Reference model: step on each rising edge, then compare against the DUT 1 time unit later
    always @(posedge clk) begin
        int   w, sel, c;
        bit   do_pop, do_push, any_req;
        ent_t e;
        if (rst) begin
            m_fifo.delete();
            m_ptr_in  = 0;
            m_ptr_out = 0;
            m_drops   = 0;
            exp_grant = '0;
            exp_din   = '0;
            exp_ovf   = 1'b0;
            for (int i = 0; i < N; i++) m_pend_v[i] = 1'b0;
        end else begin
            w = -1;
            for (int k = 0; k < N; k++) begin
                c = (m_ptr_in + k) % N;
                if (w < 0 && req_f[c] != 0) w = c;
            end
            exp_grant = '0;
            if (in_valid && w >= 0) begin
                exp_grant[w] = 1'b1;
                exp_din      = in_data;
                m_ptr_in     = (w + 1) % N;
            end
            do_pop = (m_fifo.size() > 0) && out_ready;
            sel = -1;
            for (int k = 0; k < N; k++) begin
                c = (m_ptr_out + k) % N;
                if (sel < 0 && m_pend_v[c]) sel = c;
            end
            do_push = (sel >= 0) && ((m_fifo.size() < DEPTH) || do_pop);
            if (do_pop) m_log.push_back(m_fifo.pop_front());
            if (do_push) begin
                e.id   = sel;
                e.data = m_pend_d[sel];
                m_fifo.push_back(e);
                m_pend_v[sel] = 1'b0;
                m_ptr_out     = (sel + 1) % N;
            end
            for (int i = 0; i < N; i++) begin
                if (oen_f[i] != 0) begin
                    if (m_pend_v[i]) begin
                        if (m_drops < 65535) m_drops++;
                        exp_ovf = 1'b1;
                    end else begin
                        m_pend_v[i] = 1'b1;
                        m_pend_d[i] = dout_f[i];
                    end
                end
            end
        end
        #1;
        if (chk_en) begin
            any_req = 1'b0;
            for (int i = 0; i < N; i++) if (req_f[i] != 0) any_req = 1'b1;
            check("cyc_in_ready", in_ready, any_req);
            check("cyc_grant", core_grant, exp_grant);
            check("cyc_din", core_din, exp_din);
            check("cyc_out_valid", out_valid, m_fifo.size() > 0);
            if (m_fifo.size() > 0) begin
                check("cyc_out_data", out_data, m_fifo[0].data);
                check("cyc_out_id", out_core_id, m_fifo[0].id);
            end
            check("cyc_drop_cnt", drop_cnt, m_drops);
            check("cyc_overflow", overflow, exp_ovf);
        end
    end

    task automatic wait_log(input int n, input string name);
        int b;
        b = 0;
        while (m_log.size() < n && b < 200) begin
            @(negedge clk);
            b++;
        end
        check(name, m_log.size(), n);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] neg5;
        int            exp_w [3];
        int            npend;
        n_tests = 0; n_fail = 0; chk_en = 1'b0;
        rst = 1'b1; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            req_f[i] = '0; oen_f[i] = '0; dout_f[i] = '0;
        end
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("rst_grant", core_grant, 0);
        check("rst_din", core_din, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_id", out_core_id, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        check("rst_overflow", overflow, 0);
        rst = 1'b0;

        // Fair input: cores 3, 7, 22
        @(negedge clk);
        req_f[3] = 4'h1; req_f[7] = 4'hA; req_f[22] = 4'hF;
        in_valid = 1'b1; in_data = 31'd100;
        exp_w[0] = 3; exp_w[1] = 7; exp_w[2] = 22;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("fair_grant", core_grant, onehot(exp_w[k % 3]));
            check("fair_din", core_din, 100 + k);
            in_data = DW'(101 + k);
        end
        req_f[3] = '0; req_f[7] = '0; req_f[22] = '0;
        #1;
        check("noreq_in_ready", in_ready, 0);
        @(negedge clk);
        check("noreq_grant", core_grant, 0);
        check("noreq_din_hold", core_din, 105);

        // Wrap: move ptr_in to 22, then only core 0 requests
        req_f[21] = 4'h1; in_data = 31'd7;
        @(negedge clk);
        check("wrap_pre_grant", core_grant, onehot(21));
        req_f[21] = '0; req_f[0] = 4'h2;
        neg5 = -5; in_data = neg5;
        @(negedge clk);
        check("wrap_grant", core_grant, onehot(0));
        check("wrap_din", core_din, neg5);
        req_f[1] = 4'h1; in_data = 31'd9;
        @(negedge clk);
        check("wrap_ptr_grant", core_grant, onehot(1));
        req_f[0] = '0; req_f[1] = '0; in_valid = 1'b0;

        // Burst collect from all cores
        out_ready = 1'b1;
        m_log.delete();
        for (int i = 0; i < N; i++) begin
            oen_f[i] = 4'h1; dout_f[i] = DW'(i * 10);
        end
        @(negedge clk);
        for (int i = 0; i < N; i++) oen_f[i] = '0;
        check("burst_lat_not_yet", out_valid, 0);
        @(negedge clk);
        check("burst_lat_valid", out_valid, 1);
        check("burst_first_id", out_core_id, 0);
        wait_log(N, "burst_count");
        for (int i = 0; i < N && i < m_log.size(); i++) begin
            check("burst_id", m_log[i].id, i);
            check("burst_data", m_log[i].data, i * 10);
        end
        check("burst_drop_cnt", drop_cnt, 0);

        // Backpressure and drop
        out_ready = 1'b0;
        m_log.delete();
        for (int i = 0; i < 6; i++) begin
            oen_f[i] = 4'h3; dout_f[i] = DW'(1000 + i);
        end
        @(negedge clk);
        for (int i = 0; i < 6; i++) oen_f[i] = '0;
        repeat (6) @(negedge clk);
        oen_f[5] = 4'h8; dout_f[5] = 31'd9999;
        @(negedge clk);
        oen_f[5] = '0;
        @(negedge clk);
        check("bp_drop_cnt", drop_cnt, 1);
        check("bp_overflow", overflow, 1);
        check("bp_out_valid", out_valid, 1);
        check("bp_head_id", out_core_id, 0);
        check("bp_head_data", out_data, 1000);
        check("bp_model_fill", m_fifo.size(), 4);
        check("bp_model_pend", {m_pend_v[4], m_pend_v[5]}, 2'b11);
        out_ready = 1'b1;
        wait_log(6, "bp_count");
        for (int i = 0; i < 6 && i < m_log.size(); i++) begin
            check("bp_id", m_log[i].id, i);
            check("bp_data", m_log[i].data, 1000 + i);
        end

        // Drain and refill of core 2 in the same cycle
        m_log.delete();
        oen_f[2] = 4'h1; dout_f[2] = 31'd55;
        @(negedge clk);
        dout_f[2] = 31'd77;
        @(negedge clk);
        oen_f[2] = '0;
        wait_log(2, "refill_count");
        if (m_log.size() >= 2) begin
            check("refill_id0", m_log[0].id, 2);
            check("refill_data0", m_log[0].data, 55);
            check("refill_id1", m_log[1].id, 2);
            check("refill_data1", m_log[1].data, 77);
        end
        check("refill_drop_cnt", drop_cnt, 1);

        // Reset mid-run with 3 FIFO entries and 2 pending slots
        out_ready = 1'b0;
        m_log.delete();
        for (int i = 0; i < 5; i++) begin
            oen_f[i] = 4'h1; dout_f[i] = DW'(500 + i);
        end
        @(negedge clk);
        for (int i = 0; i < 5; i++) oen_f[i] = '0;
        repeat (3) @(negedge clk);
        npend = 0;
        for (int i = 0; i < N; i++) if (m_pend_v[i]) npend++;
        check("mid_model_fill", m_fifo.size(), 3);
        check("mid_model_pend", npend, 2);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_drop_cnt", drop_cnt, 0);
        check("mid_rst_overflow", overflow, 0);
        check("mid_rst_grant", core_grant, 0);
        rst = 1'b0;
        out_ready = 1'b1;
        oen_f[9] = 4'h1; dout_f[9] = 31'd4242;
        @(negedge clk);
        oen_f[9] = '0;
        wait_log(1, "post_rst_count");
        if (m_log.size() >= 1) begin
            check("post_rst_id", m_log[0].id, 9);
            check("post_rst_data", m_log[0].data, 4242);
        end
        repeat (3) @(negedge clk);
        check("post_rst_only_one", m_log.size(), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
